// File: rtl/blink_monitor.sv
// blink_monitor: measures the high time and period of an external blink
// waveform in clock cycles. It reports when the waveform is periodic (locked)
// and when it has stopped toggling (timeout).
// Optional build macro: BLINK_MONITOR_DEGLITCH_EN. When it is defined, a
// 4-cycle stability filter sits in front of edge detection.
module blink_monitor #(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2 * CLK_FREQ,
  parameter int unsigned TOL_CYCLES     = CLK_FREQ / 1000,
  parameter int unsigned LOCK_COUNT     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blink_in,
  output logic [31:0] high_cycles,
  output logic [31:0] period_cycles,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout,
  output logic [7:0]  leds
);

  localparam int unsigned CW = 32;
  localparam int unsigned MW = 4;

  localparam logic [CW-1:0] TIMEOUT_LIM = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TOL_LIM     = CW'(TOL_CYCLES);
  localparam logic [MW-1:0] LOCK_LIM    = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------
  logic blink_meta;
  logic blink_s;
  logic blink_d;
  logic edge_lvl;
  logic rise;
  logic fall;

  // Two-flop synchroniser. These flops are left without reset so that a reset
  // taken while the input is high does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    blink_meta <= blink_in;
    blink_s    <= blink_meta;
  end

`ifdef BLINK_MONITOR_DEGLITCH_EN
  logic       blink_f;
  logic [1:0] stab_cnt;

  // Stability filter: the filtered level follows blink_s only after 4 equal cycles.
  always_ff @(posedge clk) begin
    if (blink_s == blink_f) begin
      stab_cnt <= 2'd0;
    end else if (stab_cnt == 2'd3) begin
      blink_f  <= blink_s;
      stab_cnt <= 2'd0;
    end else begin
      stab_cnt <= stab_cnt + 2'd1;
    end
  end

  assign edge_lvl = blink_f;
`else
  assign edge_lvl = blink_s;
`endif

  // Delayed copy of the edge-detection level.
  always_ff @(posedge clk) begin
    blink_d <= edge_lvl;
  end

  assign rise = edge_lvl & ~blink_d;
  assign fall = ~edge_lvl & blink_d;

  // ---------------------------------------------------------------------
  // Measurement state
  // ---------------------------------------------------------------------
  state_t          state_q,       state_d;
  logic [CW-1:0]   cnt_q,         cnt_d;
  logic [CW-1:0]   idle_cnt_q,    idle_cnt_d;
  logic [CW-1:0]   hi_lat_q,      hi_lat_d;
  logic [CW-1:0]   prev_period_q, prev_period_d;
  logic            prev_valid_q,  prev_valid_d;
  logic [MW-1:0]   match_q,       match_d;
  logic [CW-1:0]   high_d;
  logic [CW-1:0]   period_d;
  logic            meas_valid_d;
  logic            locked_d;
  logic            timeout_d;

  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   period_diff;
  logic [MW-1:0]   match_inc;

  // Saturating count, distance to the previous period, and saturating match count.
  always_comb begin
    cnt_inc     = (cnt_q >= TIMEOUT_LIM) ? cnt_q : cnt_q + CW'(1);
    period_diff = (cnt_q >= prev_period_q) ? (cnt_q - prev_period_q)
                                           : (prev_period_q - cnt_q);
    match_inc   = (match_q >= LOCK_LIM) ? match_q : match_q + MW'(1);
  end

  // Next-state, measurement publishing, lock and timeout decisions.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idle_cnt_d    = idle_cnt_q;
    hi_lat_d      = hi_lat_q;
    prev_period_d = prev_period_q;
    prev_valid_d  = prev_valid_q;
    match_d       = match_q;
    high_d        = high_cycles;
    period_d      = period_cycles;
    meas_valid_d  = 1'b0;
    locked_d      = locked;
    timeout_d     = timeout;

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d      = CW'(1);
          idle_cnt_d = '0;
          timeout_d  = 1'b0;
          state_d    = ST_HIGH;
        end else if (idle_cnt_q >= TIMEOUT_LIM) begin
          timeout_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + CW'(1);
        end
      end

      ST_HIGH: begin
        if (fall) begin
          hi_lat_d = cnt_q;
          cnt_d    = cnt_inc;
          state_d  = ST_LOW;
        end else if (cnt_q >= TIMEOUT_LIM) begin
          timeout_d    = 1'b1;
          locked_d     = 1'b0;
          match_d      = '0;
          prev_valid_d = 1'b0;
          cnt_d        = '0;
          idle_cnt_d   = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LOW: begin
        if (rise) begin
          high_d        = hi_lat_q;
          period_d      = cnt_q;
          meas_valid_d  = 1'b1;
          prev_period_d = cnt_q;
          prev_valid_d  = 1'b1;
          if (!prev_valid_q) begin
            match_d = '0;
          end else if (period_diff <= TOL_LIM) begin
            match_d = match_inc;
            if (match_inc == LOCK_LIM) begin
              locked_d = 1'b1;
            end
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
          cnt_d   = CW'(1);
          state_d = ST_HIGH;
        end else if (cnt_q >= TIMEOUT_LIM) begin
          timeout_d    = 1'b1;
          locked_d     = 1'b0;
          match_d      = '0;
          prev_valid_d = 1'b0;
          cnt_d        = '0;
          idle_cnt_d   = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idle_cnt_q    <= '0;
      hi_lat_q      <= '0;
      prev_period_q <= '0;
      prev_valid_q  <= 1'b0;
      match_q       <= '0;
      high_cycles   <= '0;
      period_cycles <= '0;
      meas_valid    <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
      leds          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      hi_lat_q      <= hi_lat_d;
      prev_period_q <= prev_period_d;
      prev_valid_q  <= prev_valid_d;
      match_q       <= match_d;
      high_cycles   <= high_d;
      period_cycles <= period_d;
      meas_valid    <= meas_valid_d;
      locked        <= locked_d;
      timeout       <= timeout_d;
      leds          <= {5'b0, blink_s, timeout_d, locked_d};
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor. Stimulus pushes the expected
// measurements; a negedge monitor pops and compares them on every meas_valid.
module tb_blink_monitor;

  logic        clk;
  logic        rst;
  logic        blink_in;
  logic [31:0] high_cycles;
  logic [31:0] period_cycles;
  logic        meas_valid;
  logic        locked;
  logic        timeout;
  logic [7:0]  leds;

  typedef struct packed {
    logic [31:0] period;
    logic [31:0] high;
    logic        lock;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  blink_monitor #(
    .CLK_FREQ   (100),
    .TOL_CYCLES (0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .blink_in      (blink_in),
    .high_cycles   (high_cycles),
    .period_cycles (period_cycles),
    .meas_valid    (meas_valid),
    .locked        (locked),
    .timeout       (timeout),
    .leds          (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    blink_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic expect_meas(input int p, input int h, input logic lk);
    exp_t e;
    e.period = 32'(p);
    e.high   = 32'(h);
    e.lock   = lk;
    exp_q.push_back(e);
  endtask

  // Monitor: every meas_valid must match the oldest expectation.
  always @(negedge clk) begin
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas: got period %0d high %0d, expected no measurement",
                 period_cycles, high_cycles);
      end else begin
        mon_e = exp_q.pop_front();
        check("meas_period", period_cycles, mon_e.period);
        check("meas_high", high_cycles, mon_e.high);
        check("meas_locked", 32'(locked), 32'(mon_e.lock));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    blink_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_high", high_cycles, 0);
    check("rst_period", period_cycles, 0);
    check("rst_valid", 32'(meas_valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_leds", 32'(leds), 0);

    // Idle timeout: input held low from reset
    drive(1'b0, 210);
    check("idle_timeout", 32'(timeout), 1);
    check("idle_leds", 32'(leds), 32'h02);

    // Steady 25 low / 75 high: lock at the 5th measurement
    cyc(75, 25);
    for (int i = 0; i < 6; i++) begin
      expect_meas(100, 75, i >= 4);
      cyc(75, 25);
    end
    check("lock_locked", 32'(locked), 1);
    check("lock_timeout_clr", 32'(timeout), 0);
    check("lock_leds", 32'(leds), 32'h01);

    // One 110-cycle period breaks lock, relock after 4 matching periods
    expect_meas(100, 75, 1'b1);
    cyc(75, 35);
    expect_meas(110, 75, 1'b0);
    cyc(75, 25);
    expect_meas(100, 75, 1'b0);
    cyc(75, 25);
    for (int i = 0; i < 4; i++) begin
      expect_meas(100, 75, i == 3);
      cyc(75, 25);
    end
    check("relock_locked", 32'(locked), 1);

    // Timeout during LOW: outputs hold, lock drops
    drive(1'b0, 250);
    check("to_timeout", 32'(timeout), 1);
    check("to_locked", 32'(locked), 0);
    check("to_leds", 32'(leds), 32'h02);
    check("to_hold_period", period_cycles, 100);
    check("to_hold_high", high_cycles, 75);
    drive(1'b1, 10);
    check("to_clear", 32'(timeout), 0);
    drive(1'b1, 65);
    drive(1'b0, 25);
    expect_meas(100, 75, 1'b0);
    cyc(75, 25);

    // Reset in the middle of HIGH
    expect_meas(100, 75, 1'b0);
    drive(1'b1, 30);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_high", high_cycles, 0);
    check("mid_rst_period", period_cycles, 0);
    check("mid_rst_valid", 32'(meas_valid), 0);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_leds", 32'(leds), 0);
    drive(1'b1, 44);
    drive(1'b0, 25);
    cyc(75, 25);
    expect_meas(100, 75, 1'b0);
    cyc(75, 25);

    // 2-cycle glitches inside the low phase
`ifdef BLINK_MONITOR_DEGLITCH_EN
    expect_meas(100, 75, 1'b0);
    expect_meas(100, 75, 1'b0);
    expect_meas(100, 75, 1'b0);
    expect_meas(100, 75, 1'b1);
`else
    expect_meas(100, 75, 1'b0);
    expect_meas(85, 75, 1'b0);
    expect_meas(15, 2, 1'b0);
    expect_meas(85, 75, 1'b0);
    expect_meas(15, 2, 1'b0);
    expect_meas(100, 75, 1'b0);
`endif
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 75);
      drive(1'b0, 10);
      drive(1'b1, 2);
      drive(1'b0, 13);
    end
    cyc(75, 25);
    cyc(75, 25);

`ifndef BLINK_MONITOR_DEGLITCH_EN
    // 1-cycle pulse is measured as high_cycles = 1
    expect_meas(100, 75, 1'b0);
    cyc(1, 99);
    expect_meas(100, 1, 1'b0);
    cyc(75, 25);
`endif

    drive(1'b0, 20);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
